// File: rtl/line_fill_buffer.sv
// Line fill buffer: assembles a 128-bit cache line from narrow memory beats, critical word first
// with wrap-around, and optionally merges a pending store word before presenting the line.
module line_fill_buffer #(
  parameter int DATA_WORDS = 8,
  parameter int LOG_WORD   = 3,
  parameter int BEAT_WORDS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fill_start,
  input  logic [LOG_WORD-1:0]        fill_word,
  input  logic                       merge_en,
  input  logic [15:0]                merge_word,
  input  logic [1:0]                 merge_be,
  input  logic                       beat_valid,
  input  logic [16*BEAT_WORDS-1:0]   beat_data,
  output logic                       beat_ready,
  output logic                       busy,
  output logic                       crit_valid,
  output logic [15:0]                crit_word,
  output logic [16*DATA_WORDS-1:0]   line_out,
  output logic                       line_valid
);

  localparam int BEATS = DATA_WORDS / BEAT_WORDS;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  // One extra bit so the transfer count cannot wrap even when BEATS == DATA_WORDS.
  localparam int CNT_W = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          bi_q, bi_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [LOG_WORD-1:0]       fw_q, fw_d;
  logic                      men_q, men_d;
  logic [15:0]               mw_q, mw_d;
  logic [1:0]                mbe_q, mbe_d;
  logic [16*DATA_WORDS-1:0]  line_q, line_d;
  logic [15:0]               crit_q, crit_d;
  logic                      cv_q, cv_d;
  logic                      lv_q, lv_d;
  logic [LOG_WORD-1:0]       off_s;
  logic [15:0]               crit_raw_s;

  function automatic logic [15:0] merge16(input logic [15:0] mem, input logic [15:0] st,
                                          input logic [1:0] be);
    return {be[1] ? st[15:8] : mem[15:8], be[0] ? st[7:0] : mem[7:0]};
  endfunction

  assign off_s      = fw_q % LOG_WORD'(BEAT_WORDS);
  assign crit_raw_s = beat_data[16*off_s +: 16];

  // Next-state, line assembly, critical-word capture and store merge.
  always_comb begin
    state_d = state_q;
    bi_d    = bi_q;
    cnt_d   = cnt_q;
    fw_d    = fw_q;
    men_d   = men_q;
    mw_d    = mw_q;
    mbe_d   = mbe_q;
    line_d  = line_q;
    crit_d  = crit_q;
    cv_d    = 1'b0;
    lv_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fill_start) begin
          fw_d    = fill_word;
          men_d   = merge_en;
          mw_d    = merge_word;
          mbe_d   = merge_be;
          bi_d    = IDX_W'(fill_word / LOG_WORD'(BEAT_WORDS));
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_FILL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (beat_valid) begin
          for (int w = 0; w < DATA_WORDS; w++) begin
            if (IDX_W'(w / BEAT_WORDS) == bi_q) begin
              line_d[16*w +: 16] = beat_data[16*(w % BEAT_WORDS) +: 16];
            end else begin
              line_d[16*w +: 16] = line_q[16*w +: 16];
            end
          end
          // The critical word always sits at the merge offset, so forward merged bytes.
          if (cnt_q == {CNT_W{1'b0}}) begin
            cv_d   = 1'b1;
            crit_d = men_q ? merge16(crit_raw_s, mw_q, mbe_q) : crit_raw_s;
          end else begin
            cv_d   = 1'b0;
          end
          bi_d    = (bi_q == IDX_W'(BEATS - 1)) ? {IDX_W{1'b0}} : bi_q + IDX_W'(1);
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_q == CNT_W'(BEATS - 1)) ? S_DONE : S_FILL;
        end else begin
          state_d = S_FILL;
        end
      end
      S_DONE: begin
        for (int w = 0; w < DATA_WORDS; w++) begin
          if (men_q && (LOG_WORD'(w) == fw_q)) begin
            line_d[16*w +: 16] = merge16(line_q[16*w +: 16], mw_q, mbe_q);
          end else begin
            line_d[16*w +: 16] = line_q[16*w +: 16];
          end
        end
        men_d   = 1'b0;
        lv_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bi_q    <= {IDX_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      fw_q    <= {LOG_WORD{1'b0}};
      men_q   <= 1'b0;
      mw_q    <= 16'h0000;
      mbe_q   <= 2'b00;
      line_q  <= {(16*DATA_WORDS){1'b0}};
      crit_q  <= 16'h0000;
      cv_q    <= 1'b0;
      lv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bi_q    <= bi_d;
      cnt_q   <= cnt_d;
      fw_q    <= fw_d;
      men_q   <= men_d;
      mw_q    <= mw_d;
      mbe_q   <= mbe_d;
      line_q  <= line_d;
      crit_q  <= crit_d;
      cv_q    <= cv_d;
      lv_q    <= lv_d;
    end
  end

  assign beat_ready = (state_q == S_FILL);
  assign busy       = (state_q != S_IDLE);
  assign crit_valid = cv_q;
  assign crit_word  = crit_q;
  assign line_out   = line_q;
  assign line_valid = lv_q;

endmodule

// File: tb/tb_line_fill_buffer.sv
// Bench for line_fill_buffer: directed vector table, reset-abort sequence and randomized fills
// against a reference model, on a 2-word-beat instance and a 1-word-beat instance.
module tb_line_fill_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  fs, bv;
  logic [2:0]  fw;
  logic        men;
  logic [15:0] mw;
  logic [1:0]  mbe;
  logic [31:0] bd;

  logic         r0, b0, cv0, lv0, r1, b1, cv1, lv1;
  logic [15:0]  cw0, cw1;
  logic [127:0] lo0, lo1;

  int sel;
  logic         ready_s, busy_s, cv_s, lv_s;
  logic [15:0]  cw_s;
  logic [127:0] lo_s;
  assign ready_s = (sel == 1) ? r1  : r0;
  assign busy_s  = (sel == 1) ? b1  : b0;
  assign cv_s    = (sel == 1) ? cv1 : cv0;
  assign lv_s    = (sel == 1) ? lv1 : lv0;
  assign cw_s    = (sel == 1) ? cw1 : cw0;
  assign lo_s    = (sel == 1) ? lo1 : lo0;

  int errors = 0;
  int checks = 0;
  int crit_seen, lv_seen;
  bit busy_bad;

  line_fill_buffer u_dut0 (
    .clk(clk), .rst_n(rst_n), .fill_start(fs[0]), .fill_word(fw), .merge_en(men),
    .merge_word(mw), .merge_be(mbe), .beat_valid(bv[0]), .beat_data(bd),
    .beat_ready(r0), .busy(b0), .crit_valid(cv0), .crit_word(cw0), .line_out(lo0),
    .line_valid(lv0)
  );

  line_fill_buffer #(.BEAT_WORDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .fill_start(fs[1]), .fill_word(fw), .merge_en(men),
    .merge_word(mw), .merge_be(mbe), .beat_valid(bv[1]), .beat_data(bd[15:0]),
    .beat_ready(r1), .busy(b1), .crit_valid(cv1), .crit_word(cw1), .line_out(lo1),
    .line_valid(lv1)
  );

  typedef struct {
    int               s;
    logic [2:0]       f;
    logic             m;
    logic [15:0]      w;
    logic [1:0]       be;
    logic [7:0][31:0] pay;
    bit               gaps;
    logic [127:0]     exp_line;
    logic [15:0]      exp_crit;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cv_s) crit_seen++;
    if (lv_s) lv_seen++;
    if (!busy_s) busy_bad = 1'b1;
  endtask

  // Reference: the j-th transfer lands in beat slot (start+j) mod beats; store bytes overlay after.
  function automatic void model(input int bw, input logic [2:0] f, input logic [7:0][31:0] pay,
                                input logic m, input logic [15:0] w, input logic [1:0] be,
                                output logic [127:0] line, output logic [15:0] crit);
    logic [15:0] wd [8];
    int beats = 8 / bw;
    int sb = int'(f) / bw;
    for (int j = 0; j < beats; j++)
      for (int k = 0; k < bw; k++)
        wd[((sb + j) % beats) * bw + k] = pay[j][16*k +: 16];
    if (m && be[0]) wd[f][7:0]  = w[7:0];
    if (m && be[1]) wd[f][15:8] = w[15:8];
    for (int i = 0; i < 8; i++) line[16*i +: 16] = wd[i];
    crit = wd[f];
  endfunction

  task automatic run_fill(input vec_t v, input string tag);
    int nb = (v.s == 1) ? 8 : 4;
    int g;
    logic [1:0] onehot = (v.s == 1) ? 2'b10 : 2'b01;
    sel = v.s;
    crit_seen = 0;
    lv_seen = 0;
    busy_bad = 1'b0;
    fs = onehot; fw = v.f; men = v.m; mw = v.w; mbe = v.be;
    tick();
    fs = 2'b00;
    bv = 2'b00;
    check({tag, "/ready"}, ready_s, 128'd1);
    for (int j = 0; j < nb; j++) begin
      g = v.gaps ? $urandom_range(0, 3) : 0;
      for (int i = 0; i < g; i++) tick();
      // A second request mid-fill with different fields must be ignored.
      if (v.gaps && j == 1) begin
        fs = onehot; fw = v.f ^ 3'd5; men = ~v.m; mbe = ~v.be;
      end
      bv = onehot;
      bd = v.pay[j];
      tick();
      fs = 2'b00;
      if (!(v.gaps && j == nb - 1)) bv = 2'b00;
      if (j == 0) begin
        check({tag, "/crit_valid"}, cv_s, 128'd1);
        check({tag, "/crit_word"}, cw_s, v.exp_crit);
      end
    end
    if (v.gaps) bd = 32'hDEAD_BEEF;
    check({tag, "/done_ctl"}, {lv_s, busy_s, ready_s}, 128'b010);
    check({tag, "/busy_held"}, busy_bad, 128'd0);
    tick();
    check({tag, "/line_valid"}, lv_s, 128'd1);
    check({tag, "/line_out"}, lo_s, v.exp_line);
    check({tag, "/crit_hold"}, cw_s, v.exp_crit);
    check({tag, "/idle_busy"}, busy_s, 128'd0);
    check({tag, "/pulse_counts"}, {crit_seen[7:0], lv_seen[7:0]}, 128'h0101);
  endtask

  logic [7:0][31:0] dp, mp, p8, rp;
  vec_t tbl [8];
  vec_t rv;

  initial begin
    rst_n = 1'b0; fs = 2'b00; bv = 2'b00; fw = 3'd0; men = 1'b0; mw = 16'h0; mbe = 2'b00;
    bd = 32'h0; sel = 0; crit_seen = 0; lv_seen = 0; busy_bad = 1'b0;

    dp = '0; mp = '0;
    dp[0] = 32'h0001_0000; dp[1] = 32'h0003_0002; dp[2] = 32'h0005_0004; dp[3] = 32'h0007_0006;
    mp[0] = 32'h1234_0022; mp[1] = 32'h0055_0044; mp[2] = 32'h0077_0066; mp[3] = 32'h0011_0000;
    for (int j = 0; j < 8; j++) p8[j] = 32'h0000_0010 + 32'(j);

    tbl[0] = '{0, 3'd0, 1'b0, 16'h0000, 2'b00, dp, 1'b0,
               128'h0007_0006_0005_0004_0003_0002_0001_0000, 16'h0000};
    tbl[1] = '{0, 3'd5, 1'b0, 16'h0000, 2'b00, dp, 1'b0,
               128'h0003_0002_0001_0000_0007_0006_0005_0004, 16'h0001};
    tbl[2] = '{0, 3'd3, 1'b1, 16'hABCD, 2'b01, mp, 1'b0,
               128'h0077_0066_0055_0044_12CD_0022_0011_0000, 16'h12CD};
    tbl[3] = '{0, 3'd6, 1'b1, 16'hABCD, 2'b10, dp, 1'b0,
               128'h0001_AB00_0007_0006_0005_0004_0003_0002, 16'hAB00};
    tbl[4] = '{0, 3'd1, 1'b1, 16'hFFFF, 2'b00, dp, 1'b0,
               128'h0007_0006_0005_0004_0003_0002_0001_0000, 16'h0001};
    tbl[5] = '{0, 3'd7, 1'b1, 16'hBEEF, 2'b11, dp, 1'b0,
               128'hBEEF_0000_0007_0006_0005_0004_0003_0002, 16'hBEEF};
    tbl[6] = '{0, 3'd0, 1'b0, 16'h0000, 2'b00, dp, 1'b1,
               128'h0007_0006_0005_0004_0003_0002_0001_0000, 16'h0000};
    tbl[7] = '{1, 3'd7, 1'b0, 16'h0000, 2'b00, p8, 1'b0,
               128'h0010_0017_0016_0015_0014_0013_0012_0011, 16'h0010};

    repeat (2) @(posedge clk);
    #1;
    check("reset0", {lo0, cw0, r0, b0, cv0, lv0} == '0, 128'd1);
    check("reset1", {lo1, cw1, r1, b1, cv1, lv1} == '0, 128'd1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_fill(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a fill: everything clears at once and no line_valid follows.
    sel = 0; bv = 2'b00; fs = 2'b01; fw = 3'd1; men = 1'b0;
    tick();
    fs = 2'b00;
    for (int j = 0; j < 2; j++) begin
      bv = 2'b01; bd = dp[j];
      tick();
    end
    bv = 2'b00;
    rst_n = 1'b0;
    #1;
    check("abort_line", lo0, 128'd0);
    check("abort_ctl", {cw0, r0, b0, cv0, lv0}, 128'd0);
    lv_seen = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("abort_no_lv", lv_seen, 128'd0);
    run_fill(tbl[1], "after_abort");

    for (int n = 0; n < 24; n++) begin
      rv.s = $urandom_range(0, 1);
      rv.f = 3'($urandom);
      rv.m = 1'($urandom);
      rv.w = 16'($urandom);
      rv.be = 2'($urandom);
      for (int j = 0; j < 8; j++) rp[j] = $urandom;
      rv.pay = rp;
      rv.gaps = 1'($urandom);
      model((rv.s == 1) ? 1 : 2, rv.f, rv.pay, rv.m, rv.w, rv.be, rv.exp_line, rv.exp_crit);
      run_fill(rv, $sformatf("rand%0d", n));
    end

    bv = 2'b00;
    lv_seen = 0;
    tick();
    check("final_lv_low", lv_seen, 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_fill_buffer.md
Name: line_fill_buffer

Overview:
- Assembles one 128-bit cache line (lc3b_block) from a narrow physical-memory burst, fetching the critical word first with wrap-around.
- Optionally merges a pending store word into the line, for write-allocate on a store miss.
- Feeds the cache data array and the downstream word-select stage.
- Raises an early critical-word strobe so the datapath can restart before the line completes.

Parameters:
- DATA_WORDS, 8, 16-bit words per line; must equal 128/16 for lc3b_block.
- LOG_WORD, 3, word-offset width, log2(DATA_WORDS).
- BEAT_WORDS, 2, 16-bit words per memory beat; must divide DATA_WORDS. BEATS = DATA_WORDS/BEAT_WORDS (derived, default 4).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fill_start  in  1  request a new line fill; accepted only in IDLE.
- fill_word  in  LOG_WORD  critical word offset within the line.
- merge_en  in  1  store to merge; sampled with fill_start.
- merge_word  in  16  store data; sampled with fill_start.
- merge_be  in  2  byte enables: bit0 = [7:0], bit1 = [15:8].
- beat_valid  in  1  memory beat present.
- beat_data  in  16*BEAT_WORDS  beat payload; word k of the beat is bits [16k+15:16k].
- beat_ready  out  1  buffer accepts a beat this cycle.
- busy  out  1  fill in progress (FILL or DONE).
- crit_valid  out  1  one-cycle pulse: critical word available.
- crit_word  out  16  critical word, held until the next accepted fill_start.
- line_out  out  128  assembled line (lc3b_block).
- line_valid  out  1  one-cycle pulse: line_out is complete and merged.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state = IDLE; beat counter = 0.
  - line_out = 0, crit_word = 0.
  - beat_ready, busy, crit_valid, line_valid = 0.
  - Pending merge cleared.
  - Reset during FILL aborts the fill; no line_valid is ever produced for it.
- IDLE:
  - beat_ready = 0, busy = 0.
  - On fill_start, latch fill_word, merge_en, merge_word, merge_be and fill_word. Set start beat sb = fill_word / BEAT_WORDS and beat index bi = sb. Clear beat count. Go to FILL.
  - line_out keeps its previous value until overwritten.
- FILL:
  - beat_ready = 1, busy = 1.
  - A beat transfers when beat_valid && beat_ready. On transfer, write beat_data into words [bi*BEAT_WORDS .. bi*BEAT_WORDS+BEAT_WORDS-1] of line_out.
  - After each transfer: bi = (bi+1) mod BEATS (wrap-around), count += 1.
  - Transfer of beat sb (the first transfer): next cycle crit_valid = 1 for one cycle, crit_word = beat word (fill_word mod BEAT_WORDS).
    - If merge_en and fill_word matches the merge offset, crit_word carries the merged bytes, so the datapath never sees stale store data.
  - Transfer number BEATS (count reaches BEATS-1 before increment): go to DONE.
  - beat_valid with no transfer is ignored; gaps between beats are allowed.
  - fill_start while busy is ignored; latched fields are unchanged.
- DONE (one cycle):
  - busy = 1, beat_ready = 0.
  - If merge pending: line_out word[merge offset] bytes with merge_be=1 are replaced by merge_word bytes; bytes with merge_be=0 keep memory data. merge_be=00 leaves the line unchanged.
  - line_valid = 1 on the cycle after the merge is written, i.e. line_out is stable and final whenever line_valid = 1.
  - Then return to IDLE.
- Latency: fill_start to first beat_ready is 1 cycle. Final beat to line_valid is 2 cycles. Back-to-back fills are possible: fill_start may be asserted in the cycle line_valid is high.
- Widths: beat index is log2(BEATS) bits; wrap uses natural overflow when BEATS is a power of two. The counter must not overflow for BEATS = DATA_WORDS (BEAT_WORDS = 1).

Test Plan:
- Reset, then fill_start with fill_word=0 and 4 back-to-back beats 0x0001_0000, 0x0003_0002, 0x0005_0004, 0x0007_0006 -> words 0..7 = 0x0000..0x0007; crit_valid once with crit_word=0x0000; line_valid exactly 2 cycles after the last beat.
- fill_word=5 (sb=2), same beat payloads in order -> beats land in slots 2,3,0,1; line words = payloads rotated accordingly; crit_word = word 5 of line = upper word of the first beat.
- merge_en=1, fill_word=3, merge_word=0xABCD, merge_be=01, memory word3=0x1234 -> final word3=0x12CD; crit_word=0x12CD; other words untouched.
- Beats with beat_valid gaps of 0–3 idle cycles, plus fill_start pulsed mid-fill -> identical line to the gap-free case; second request ignored; busy held high throughout.
- Assert rst_n=0 after 2 of 4 beats -> line_out=0 and all outputs 0 immediately; no line_valid. New fill after release completes correctly.
- BEAT_WORDS=1 (BEATS=8), fill_word=7 -> order 7,0,1,..,6; count terminates after 8 transfers; line_valid asserted once.
